// File: rtl/dac_spi_writer_pkg.sv
// Shared constants for the MCP4921-class DAC writer: state encoding,
// command-nibble bits and frame geometry.
package dac_spi_writer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_SCK_LO = 3'd2;
  localparam logic [2:0] ST_SCK_HI = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_LDAC   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    SCK_LO = ST_SCK_LO,
    SCK_HI = ST_SCK_HI,
    HOLD   = ST_HOLD,
    LDAC   = ST_LDAC
  } state_t;

  // Command nibble, MSB first: A/B select, buffer, gain select (1 = 1x), shutdown (1 = active)
  localparam logic DAC_A  = 1'b0;
  localparam logic BUF    = 1'b0;
  localparam logic GAIN1X = 1'b1;
  localparam logic ACTIVE = 1'b1;
  localparam logic [3:0] CONFIG_DEFAULT = {DAC_A, BUF, GAIN1X, ACTIVE};

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  function automatic logic [FRAME_BITS-1:0] build_word(input logic [3:0] cfg,
                                                       input logic [DATA_BITS-1:0] value);
    return {cfg, value};
  endfunction

endpackage

// File: rtl/dac_spi_writer_phase_timer.sv
// Down-counter that times every CLKDIV-long phase of the SPI frame; tc is
// high during the last cycle of the phase that was started by load.
module dac_spi_phase_timer #(
  parameter int CLKDIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);

  localparam int W = $clog2(CLKDIV + 1);
  localparam logic [W-1:0] RELOAD = W'(CLKDIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/dac_spi_writer.sv
// Serialises {CONFIG, data} to an SPI DAC (mode 0, MSB first), pulses LDAC
// afterwards, and buffers one value that arrives while a frame is running.
module dac_spi_writer
  import dac_spi_writer_pkg::*;
#(
  parameter int         CLKDIV = 5,
  parameter logic [3:0] CONFIG = CONFIG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set,
  input  logic [DATA_BITS-1:0] data,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 ldac_n,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  state_t                state, state_d;
  logic [FRAME_BITS-1:0] shreg, shreg_d;
  logic [FRAME_BITS-1:0] start_word;
  logic [4:0]            bit_cnt, bit_cnt_d;
  logic                  pend_valid, pend_valid_d;
  logic [DATA_BITS-1:0]  pend_data, pend_data_d;
  logic                  mosi_d, done_d, overrun_d;
  logic                  cs_n_d, sclk_d, ldac_n_d, busy_d;
  logic                  phase_load, phase_tc;

  dac_spi_phase_timer #(
    .CLKDIV(CLKDIV)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (phase_load),
    .tc   (phase_tc)
  );

  // A buffered value always goes out before a strobe arriving in the same cycle
  always_comb begin
    state_d      = state;
    shreg_d      = shreg;
    bit_cnt_d    = bit_cnt;
    pend_valid_d = pend_valid;
    pend_data_d  = pend_data;
    mosi_d       = mosi;
    done_d       = 1'b0;
    overrun_d    = 1'b0;
    phase_load   = 1'b0;
    start_word   = build_word(CONFIG, pend_valid ? pend_data : data);

    case (state)
      IDLE: begin
        if (pend_valid || set) begin
          state_d    = SETUP;
          shreg_d    = start_word;
          mosi_d     = start_word[FRAME_BITS-1];
          bit_cnt_d  = '0;
          phase_load = 1'b1;
          if (pend_valid) begin
            pend_valid_d = set;
            if (set) begin
              pend_data_d = data;
            end
          end
        end
      end
      SETUP: begin
        if (phase_tc) begin
          state_d    = SCK_LO;
          phase_load = 1'b1;
        end
      end
      SCK_LO: begin
        if (phase_tc) begin
          state_d    = SCK_HI;
          phase_load = 1'b1;
        end
      end
      SCK_HI: begin
        if (phase_tc) begin
          phase_load = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            state_d   = SCK_LO;
            bit_cnt_d = bit_cnt + 5'd1;
            shreg_d   = {shreg[FRAME_BITS-2:0], 1'b0};
            mosi_d    = shreg[FRAME_BITS-2];
          end
        end
      end
      HOLD: begin
        if (phase_tc) begin
          state_d    = LDAC;
          phase_load = 1'b1;
          mosi_d     = 1'b0;
        end
      end
      LDAC: begin
        if (phase_tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state != IDLE && set) begin
      pend_data_d  = data;
      pend_valid_d = 1'b1;
      overrun_d    = pend_valid;
    end
  end

  // Pin levels follow the state being entered so every output is a flop
  always_comb begin
    cs_n_d   = !(state_d == SETUP || state_d == SCK_LO ||
                 state_d == SCK_HI || state_d == HOLD);
    sclk_d   = (state_d == SCK_HI);
    ldac_n_d = (state_d != LDAC);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      bit_cnt    <= bit_cnt_d;
      pend_valid <= pend_valid_d;
      pend_data  <= pend_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ldac_n  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cs_n    <= cs_n_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      ldac_n  <= ldac_n_d;
      busy    <= busy_d;
      done    <= done_d;
      overrun <= overrun_d;
    end
  end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Self-checking bench: two DAC writers (CLKDIV=5 and CLKDIV=1) checked
// cycle by cycle against a frame-timing reference model.
module tb_dac_spi_writer;

  localparam int D0 = 5;
  localparam int D1 = 1;
  localparam logic [3:0] CMD = 4'b0011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i[2];
  logic        set_i[2];
  logic [11:0] data_i[2];
  logic        cs_o[2], sclk_o[2], mosi_o[2], ldac_o[2], busy_o[2], done_o[2], ovr_o[2];

  dac_spi_writer #(.CLKDIV(D0)) dut5 (
    .clk(clk), .rst_n(rst_i[0]), .set(set_i[0]), .data(data_i[0]),
    .cs_n(cs_o[0]), .sclk(sclk_o[0]), .mosi(mosi_o[0]), .ldac_n(ldac_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .overrun(ovr_o[0])
  );

  dac_spi_writer #(.CLKDIV(D1)) dut1 (
    .clk(clk), .rst_n(rst_i[1]), .set(set_i[1]), .data(data_i[1]),
    .cs_n(cs_o[1]), .sclk(sclk_o[1]), .mosi(mosi_o[1]), .ldac_n(ldac_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .overrun(ovr_o[1])
  );

  // Pin vector {cs_n, sclk, mosi, ldac_n, busy, done, overrun} o edges after a frame start
  function automatic logic [6:0] expected_pins(bit act, int o, logic [15:0] w, bit ov, int d);
    logic cs_n, sclk, mosi, ldac_n, busy, done;
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; ldac_n = 1'b1; busy = 1'b0; done = 1'b0;
    if (act && o < 34*d) begin
      cs_n = 1'b0;
      busy = 1'b1;
      if (o < d) mosi = w[15];
      else if (o < 33*d) begin
        sclk = (((o - d) / d) % 2) == 1;
        mosi = w[15 - (o - d) / (2*d)];
      end else mosi = w[0];
    end else if (act && o < 35*d) begin
      ldac_n = 1'b0;
      busy   = 1'b1;
    end else if (act && o == 35*d) begin
      done = 1'b1;
    end
    return {cs_n, sclk, mosi, ldac_n, busy, done, ov};
  endfunction

  logic [6:0]  exp_out[2];
  logic [15:0] exp_word[2];

  for (genvar g = 0; g < 2; g++) begin : ref_model
    localparam int D = (g == 0) ? D0 : D1;
    int          off;
    bit          active, pend, ovr;
    logic [11:0] pdata;
    logic [15:0] word;

    always @(posedge clk or negedge rst_i[g]) begin
      if (!rst_i[g]) begin
        active <= 1'b0; off <= 0; pend <= 1'b0; pdata <= '0; word <= '0; ovr <= 1'b0;
      end else begin
        ovr <= 1'b0;
        if (!active || off >= 35*D) begin
          if (pend) begin
            word <= {CMD, pdata}; active <= 1'b1; off <= 0; pend <= set_i[g];
            if (set_i[g]) pdata <= data_i[g];
          end else if (set_i[g]) begin
            word <= {CMD, data_i[g]}; active <= 1'b1; off <= 0;
          end else begin
            active <= 1'b0;
          end
        end else begin
          off <= off + 1;
          if (set_i[g]) begin
            ovr <= pend; pend <= 1'b1; pdata <= data_i[g];
          end
        end
      end
    end

    assign exp_out[g]  = expected_pins(active, off, word, ovr, D);
    assign exp_word[g] = word;
  end

  int errors = 0;
  int checks = 0;

  bit          pcs[2], pscl[2], pld[2];
  logic [15:0] cap[2], last_word[2];
  int          nbits[2], cs_run[2], last_cs_run[2], ld_run[2], last_ld_run[2];
  int          n_done[2], n_ovr[2], n_ldac[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input int u, input logic s, input logic [11:0] d);
    set_i[u]  = s;
    data_i[u] = d;
  endtask

  task automatic checkOutput();
    logic [6:0] act;
    for (int u = 0; u < 2; u++) begin
      act = {cs_o[u], sclk_o[u], mosi_o[u], ldac_o[u], busy_o[u], done_o[u], ovr_o[u]};
      checks++;
      if (act !== exp_out[u]) begin
        errors++;
        $display("[TB] FAIL pins dut%0d at %0t: got %b, expected %b", u, $time, act, exp_out[u]);
      end
      if (!rst_i[u]) begin
        pcs[u] = 1'b1; pscl[u] = 1'b0; pld[u] = 1'b1; nbits[u] = 0; cs_run[u] = 0; ld_run[u] = 0;
        continue;
      end
      if (pcs[u] && !cs_o[u]) begin nbits[u] = 0; cap[u] = '0; cs_run[u] = 0; end
      if (!cs_o[u]) cs_run[u]++;
      if (!pscl[u] && sclk_o[u]) begin cap[u] = {cap[u][14:0], mosi_o[u]}; nbits[u]++; end
      if (!pcs[u] && cs_o[u]) begin
        last_cs_run[u] = cs_run[u];
        last_word[u]   = cap[u];
        checks++;
        if (nbits[u] != 16 || cap[u] !== exp_word[u]) begin
          errors++;
          $display("[TB] FAIL frame dut%0d at %0t: got %0d bits %h, expected 16 bits %h",
                   u, $time, nbits[u], cap[u], exp_word[u]);
        end
      end
      if (pld[u] && !ldac_o[u]) ld_run[u] = 0;
      if (!ldac_o[u]) ld_run[u]++;
      if (!pld[u] && ldac_o[u]) begin last_ld_run[u] = ld_run[u]; n_ldac[u]++; end
      if (done_o[u]) n_done[u]++;
      if (ovr_o[u]) n_ovr[u]++;
      pcs[u] = cs_o[u]; pscl[u] = sclk_o[u]; pld[u] = ldac_o[u];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic pulse(input int u, input logic [11:0] d);
    applyStimulus(u, 1'b1, d);
    cycle();
    applyStimulus(u, 1'b0, d);
  endtask

  task automatic wait_done(input int u, input int maxc, output int lat);
    lat = 0;
    while (!done_o[u] && lat < maxc) begin
      cycle();
      lat++;
    end
    if (!done_o[u]) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout dut%0d: no done within %0d cycles", u, maxc);
    end
  endtask

  typedef struct {
    int          u;
    logic [11:0] d;
    logic [15:0] word;
    int          cs_low;
    int          ld_low;
    int          lat;
  } vec_t;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   lat, o0, d0, l0;

    vecs[0] = '{0, 12'hABC, 16'h3ABC, 170, 5, 175};
    vecs[1] = '{1, 12'h000, 16'h3000, 34, 1, 35};
    vecs[2] = '{1, 12'hFFF, 16'h3FFF, 34, 1, 35};
    vecs[3] = '{0, 12'h5A5, 16'h35A5, 170, 5, 175};

    for (int u = 0; u < 2; u++) begin
      rst_i[u] = 1'b0; set_i[u] = 1'b0; data_i[u] = '0;
      pcs[u] = 1'b1; pld[u] = 1'b1; pscl[u] = 1'b0; cap[u] = '0;
      n_done[u] = 0; n_ovr[u] = 0; n_ldac[u] = 0;
    end
    repeat (3) cycle();
    for (int u = 0; u < 2; u++)
      check($sformatf("reset_pins%0d", u),
            {cs_o[u], sclk_o[u], mosi_o[u], ldac_o[u], busy_o[u], done_o[u], ovr_o[u]}, 7'b1001000);
    rst_i[0] = 1'b1; rst_i[1] = 1'b1;
    repeat (2) cycle();

    // Single frames from the vector table
    for (int i = 0; i < 4; i++) begin
      o0 = n_ovr[vecs[i].u];
      pulse(vecs[i].u, vecs[i].d);
      wait_done(vecs[i].u, 400, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_word", i), last_word[vecs[i].u], vecs[i].word);
      check($sformatf("v%0d_cs_low", i), last_cs_run[vecs[i].u], vecs[i].cs_low);
      check($sformatf("v%0d_ldac_low", i), last_ld_run[vecs[i].u], vecs[i].ld_low);
      check($sformatf("v%0d_no_ovr", i), n_ovr[vecs[i].u] - o0, 0);
      repeat (3) cycle();
    end

    // Two strobes while busy: newest wins, one overrun
    o0 = n_ovr[0]; d0 = n_done[0];
    pulse(0, 12'h123);
    repeat (19) cycle();
    pulse(0, 12'h456);
    repeat (19) cycle();
    pulse(0, 12'h789);
    check("ovr_at_40", ovr_o[0], 1);
    wait_done(0, 400, lat);
    check("first_done_lat", lat, 135);
    check("ovr_once", n_ovr[0] - o0, 1);
    cycle();
    check("pend_start_cs", cs_o[0], 0);
    wait_done(0, 400, lat);
    check("pend_word", last_word[0], 16'h3789);
    check("pend_lat", lat, 175);
    repeat (10) cycle();
    check("two_frames", n_done[0] - d0, 2);

    // Reset in mid-frame with a value pending
    d0 = n_done[0]; l0 = n_ldac[0];
    pulse(0, 12'hABC);
    repeat (49) cycle();
    pulse(0, 12'h321);
    repeat (29) cycle();
    #1 rst_i[0] = 1'b0;
    #1;
    check("rst_cs_n", cs_o[0], 1);
    check("rst_sclk", sclk_o[0], 0);
    check("rst_ldac_n", ldac_o[0], 1);
    check("rst_busy", busy_o[0], 0);
    repeat (3) cycle();
    rst_i[0] = 1'b1;
    repeat (200) cycle();
    check("rst_no_done", n_done[0] - d0, 0);
    check("rst_no_ldac", n_ldac[0] - l0, 0);
    pulse(0, 12'h555);
    wait_done(0, 400, lat);
    check("post_rst_word", last_word[0], 16'h3555);
    check("post_rst_lat", lat, 175);
    repeat (3) cycle();

    // Strobe during the done cycle starts the next frame at once
    pulse(0, 12'h111);
    wait_done(0, 400, lat);
    check("done_busy_low", busy_o[0], 0);
    o0 = n_ovr[0];
    applyStimulus(0, 1'b1, 12'h222);
    cycle();
    applyStimulus(0, 1'b0, 12'h222);
    check("coinc_cs", cs_o[0], 0);
    check("coinc_busy", busy_o[0], 1);
    check("coinc_ovr", ovr_o[0], 0);
    wait_done(0, 400, lat);
    check("coinc_word", last_word[0], 16'h3222);
    check("coinc_no_ovr", n_ovr[0] - o0, 0);
    repeat (3) cycle();

    // Slow ramp counter feeding values 1..8, one every 1000 cycles
    o0 = n_ovr[0]; l0 = n_ldac[0];
    for (int i = 1; i <= 8; i++) begin
      pulse(0, 12'(i));
      wait_done(0, 400, lat);
      check($sformatf("ramp%0d_word", i), last_word[0], {CMD, 12'(i)});
      repeat (999 - lat) cycle();
    end
    check("ramp_ldac_pulses", n_ldac[0] - l0, 8);
    check("ramp_no_ovr", n_ovr[0] - o0, 0);

    // Random strobes on both instances, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(0, $urandom_range(0, 39) == 0, 12'($urandom));
      applyStimulus(1, $urandom_range(0, 7) == 0, 12'($urandom));
      cycle();
    end
    applyStimulus(0, 1'b0, '0);
    applyStimulus(1, 1'b0, '0);
    repeat (400) cycle();
    check("idle_busy0", busy_o[0], 0);
    check("idle_busy1", busy_o[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
